gpio_handoff_ctrl: RTL and testbench
====================================

# gpio_handoff_ctrl

Sequencer that drives the GPIO block's register-access port to perform the boot-to-host handoff handshake. It enables and raises the handoff output pin, polls the GPIO input-data register until the host acknowledges on the ack pin, then releases the handoff pin. It sits between boot/security control logic (start/abort/status) and the GPIO block's `reg_access`/`reg_packet`/`reg_rdata` interface, and is the sole master of that interface while busy.

## Interface
- N, 24, GPIO pin count
- AW, 32, address width
- PW, 2*AW+40, emesh packet width
- HO_BIT, 4, gpio_out index of the handoff pin
- ACK_BIT, 5, gpio_in / IDATA index of the host ack pin
- OEN_ADDR, 32'h0, dstaddr of the GPIO output-enable register
- ODATA_ADDR, 32'h8, dstaddr of the GPIO output-data register
- IDATA_ADDR, 32'h10, dstaddr of the GPIO input-data register
- RD_LAT, 1, cycles from read packet to valid reg_rdata (1..3)
- POLL_GAP, 8, idle cycles between polls (≥1)
- TO_W, 16, timeout counter width
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  single-cycle request to begin handoff; ignored while busy
- abort  in  1  force release of the handoff pin and terminate
- timeout_lim  in  TO_W  maximum poll count before timeout (0 = one poll only)
- oen_base  in  N  output-enable bits to preserve; HO_BIT is OR'd in
- odata_base  in  N  output-data bits to preserve; HO_BIT set/cleared over these
- reg_rdata  in  32  GPIO readback data
- reg_access  out  1  GPIO register access strobe
- reg_packet  out  PW  emesh packet: [0] write, [2:1] datamode = 2'b10, [7:3] ctrlmode = 0, [39:8] dstaddr, [71:40] data (zero-extended), [103:72] srcaddr = 0
- busy  out  1  sequence in progress
- handed_off  out  1  high from ASSERT write until RELEASE write
- done  out  1  one-cycle pulse: ack received and pin released
- timeout  out  1  one-cycle pulse: no ack within limit or abort; pin released

## Operation
- States: IDLE, CFG_OEN, ASSERT, POLL_REQ, POLL_WAIT, CHECK, GAP, RELEASE, FIN.
- IDLE: start=1 → CFG_OEN; latch timeout_lim, oen_base, odata_base; clear poll counter.
- CFG_OEN: write OEN_ADDR, data = oen_base | (1<<HO_BIT) → ASSERT.
- ASSERT: write ODATA_ADDR, data = odata_base | (1<<HO_BIT); set handed_off → POLL_REQ.
- POLL_REQ: read packet (write=0) to IDATA_ADDR → POLL_WAIT; wait counter = RD_LAT.
- POLL_WAIT: count down; at 0 sample reg_rdata → CHECK.
- CHECK: if sampled[ACK_BIT]=1, set ok → RELEASE. Else if poll count == latched limit, set ok=0 → RELEASE. Else increment poll count → GAP.
- GAP: idle POLL_GAP cycles → POLL_REQ.
- RELEASE: write ODATA_ADDR, data = odata_base & ~(1<<HO_BIT); clear handed_off → FIN.
- FIN: pulse done (ok) or timeout (!ok) → IDLE.
- abort=1 in any state from ASSERT through GAP → RELEASE with ok=0, discarding any pending read. abort in CFG_OEN → IDLE with a timeout pulse and no writes beyond the OEN write. abort in IDLE, RELEASE or FIN is ignored.
- start and abort both high in IDLE: start is ignored.
- Poll counter is TO_W bits and saturates; the compare uses ==, so no wrap is possible.

## Timing
- Reset: reg_access=0, reg_packet=0, busy=0, handed_off=0, done=0, timeout=0; state=IDLE. Reset mid-sequence leaves the pin state to the GPIO block's own reset; no release write is issued.
- All outputs are registered. reg_access is high for exactly one cycle per packet, and reg_packet is valid in that cycle; it is 0 otherwise.
- start at cycle 0 → OEN write at cycle 1, ODATA set at cycle 2, first read at cycle 3, sample at cycle 3+RD_LAT+1.
- Poll period = 1 + RD_LAT + 1 + POLL_GAP cycles.
- Ack on the first poll → RELEASE write at cycle 3+RD_LAT+2, done at the next cycle; busy falls with the done/timeout pulse.
- busy is high from the cycle after start through the FIN cycle. At most one packet is outstanding at a time.

## Test plan
- Ack immediate: gpio_in[5]=1 before start, RD_LAT=1 → packets OEN(0x10), ODATA(0x10), IDATA read, ODATA(0x00); done pulses at cycle 7; timeout stays 0.
- Ack after 3 polls, POLL_GAP=8 → exactly 4 read packets spaced 11 cycles apart, then release write and done; handed_off high from cycle 2 until the release cycle.
- Timeout: ack stuck 0, timeout_lim=2 → 3 reads, release write with data = odata_base & ~0x10, timeout pulse, done=0.
- Base preservation: odata_base=0x000101, oen_base=0x0000FF → writes 0x0000FF|0x10, 0x000111, then 0x000101.
- Abort during GAP → next cycle RELEASE write, then timeout pulse; no further reads. start while busy is ignored.
- Synchronous reset asserted in POLL_WAIT → next cycle all outputs 0 and state IDLE; a following start runs a full sequence normally.

Source files
------------

// File: rtl/gpio_handoff_ctrl.sv
// Boot-to-host handoff sequencer: drives the GPIO register port to raise the
// handoff pin, polls the input-data register for the host ack, then releases the pin.
module gpio_handoff_ctrl #(
    parameter int          N          = 24,
    parameter int          AW         = 32,
    parameter int          PW         = 2*AW+40,
    parameter int          HO_BIT     = 4,
    parameter int          ACK_BIT    = 5,
    parameter logic [31:0] OEN_ADDR   = 32'h0,
    parameter logic [31:0] ODATA_ADDR = 32'h8,
    parameter logic [31:0] IDATA_ADDR = 32'h10,
    parameter int          RD_LAT     = 1,
    parameter int          POLL_GAP   = 8,
    parameter int          TO_W       = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            abort,
    input  logic [TO_W-1:0] timeout_lim,
    input  logic [N-1:0]    oen_base,
    input  logic [N-1:0]    odata_base,
    input  logic [31:0]     reg_rdata,
    output logic            reg_access,
    output logic [PW-1:0]   reg_packet,
    output logic            busy,
    output logic            handed_off,
    output logic            done,
    output logic            timeout
);

    localparam int          GW      = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam logic [N-1:0] HO_MASK = N'(1) << HO_BIT;

    typedef enum logic [3:0] {
        IDLE, CFG_OEN, ASSERT, POLL_REQ, POLL_WAIT, CHECK, GAP, RELEASE, FIN
    } state_t;

    state_t          state, state_n;
    logic [TO_W-1:0] lim_q, poll_cnt, poll_cnt_n;
    logic [N-1:0]    odata_q;
    logic [1:0]      wait_cnt, wait_cnt_n;
    logic [GW-1:0]   gap_cnt, gap_cnt_n;
    logic            ok_q, ok_n, ack_q, ack_n;
    logic            latch_en, abort_to;
    logic            access_n, busy_n, handed_n, done_n, timeout_n;
    logic [PW-1:0]   pkt_n;
    logic            unused_rdata;

    assign unused_rdata = ^reg_rdata;

    function automatic logic [PW-1:0] build_pkt(input logic wr, input logic [AW-1:0] addr,
                                                input logic [AW-1:0] data);
        logic [PW-1:0] p;
        p              = '0;
        p[0]           = wr;
        p[2:1]         = 2'b10;
        p[AW+7:8]      = addr;
        p[2*AW+7:AW+8] = data;
        return p;
    endfunction

    always_comb begin
        state_n    = state;
        poll_cnt_n = poll_cnt;
        wait_cnt_n = wait_cnt;
        gap_cnt_n  = gap_cnt;
        ok_n       = ok_q;
        ack_n      = ack_q;
        latch_en   = 1'b0;
        abort_to   = 1'b0;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_n    = CFG_OEN;
                    latch_en   = 1'b1;
                    poll_cnt_n = '0;
                end
            end
            CFG_OEN: begin
                if (abort) begin
                    state_n  = IDLE;
                    abort_to = 1'b1;
                end else begin
                    state_n = ASSERT;
                end
            end
            ASSERT:   state_n = POLL_REQ;
            POLL_REQ: begin
                state_n    = POLL_WAIT;
                wait_cnt_n = 2'(RD_LAT-1);
            end
            POLL_WAIT: begin
                // Stay RD_LAT cycles so the sample lands on the readback cycle.
                if (wait_cnt == 2'd0) begin
                    ack_n   = reg_rdata[ACK_BIT];
                    state_n = CHECK;
                end else begin
                    wait_cnt_n = wait_cnt - 2'd1;
                end
            end
            CHECK: begin
                if (ack_q) begin
                    ok_n    = 1'b1;
                    state_n = RELEASE;
                end else if (poll_cnt == lim_q) begin
                    ok_n    = 1'b0;
                    state_n = RELEASE;
                end else begin
                    if (poll_cnt != {TO_W{1'b1}})
                        poll_cnt_n = poll_cnt + 1'b1;
                    gap_cnt_n = GW'(POLL_GAP-1);
                    state_n   = GAP;
                end
            end
            GAP: begin
                if (gap_cnt == '0) state_n = POLL_REQ;
                else               gap_cnt_n = gap_cnt - 1'b1;
            end
            RELEASE: state_n = FIN;
            FIN:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
        // Once the pin is driven high an abort must still produce the release write.
        if (abort && (state inside {ASSERT, POLL_REQ, POLL_WAIT, CHECK, GAP})) begin
            state_n = RELEASE;
            ok_n    = 1'b0;
        end
    end

    always_comb begin
        access_n = 1'b0;
        pkt_n    = '0;
        case (state_n)
            CFG_OEN: begin
                access_n = 1'b1;
                pkt_n    = build_pkt(1'b1, AW'(OEN_ADDR), AW'(oen_base | HO_MASK));
            end
            ASSERT: begin
                access_n = 1'b1;
                pkt_n    = build_pkt(1'b1, AW'(ODATA_ADDR), AW'(odata_q | HO_MASK));
            end
            POLL_REQ: begin
                access_n = 1'b1;
                pkt_n    = build_pkt(1'b0, AW'(IDATA_ADDR), '0);
            end
            RELEASE: begin
                access_n = 1'b1;
                pkt_n    = build_pkt(1'b1, AW'(ODATA_ADDR), AW'(odata_q & ~HO_MASK));
            end
            default: ;
        endcase
        busy_n    = (state_n != IDLE);
        handed_n  = (state_n inside {ASSERT, POLL_REQ, POLL_WAIT, CHECK, GAP});
        done_n    = (state_n == FIN) && ok_n;
        timeout_n = ((state_n == FIN) && !ok_n) || abort_to;
    end

    // Outputs are registered from the next state so each packet appears in the
    // cycle its state is occupied.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            poll_cnt   <= '0;
            wait_cnt   <= '0;
            gap_cnt    <= '0;
            ok_q       <= 1'b0;
            ack_q      <= 1'b0;
            reg_access <= 1'b0;
            reg_packet <= '0;
            busy       <= 1'b0;
            handed_off <= 1'b0;
            done       <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            state      <= state_n;
            poll_cnt   <= poll_cnt_n;
            wait_cnt   <= wait_cnt_n;
            gap_cnt    <= gap_cnt_n;
            ok_q       <= ok_n;
            ack_q      <= ack_n;
            reg_access <= access_n;
            reg_packet <= pkt_n;
            busy       <= busy_n;
            handed_off <= handed_n;
            done       <= done_n;
            timeout    <= timeout_n;
        end
    end

    always_ff @(posedge clk) begin
        if (latch_en) begin
            lim_q   <= timeout_lim;
            odata_q <= odata_base;
        end
    end

endmodule

// File: tb/tb_gpio_handoff_ctrl.sv
// Directed bench for gpio_handoff_ctrl: table of full handoff sequences plus
// hand-written abort, start-while-busy and mid-sequence reset cases.
module tb_gpio_handoff_ctrl;

    localparam logic [31:0] ACK   = 32'h0000_0020;
    localparam logic [31:0] NOACK = 32'hFFFF_FFDF;

    logic          clk = 1'b0;
    logic          reset, start, abort;
    logic [15:0]   timeout_lim;
    logic [23:0]   oen_base, odata_base;
    logic [31:0]   reg_rdata;
    logic          reg_access;
    logic [103:0]  reg_packet;
    logic          busy, handed_off, done, timeout;

    always #5 clk = ~clk;

    gpio_handoff_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .timeout_lim(timeout_lim), .oen_base(oen_base), .odata_base(odata_base),
        .reg_rdata(reg_rdata), .reg_access(reg_access), .reg_packet(reg_packet),
        .busy(busy), .handed_off(handed_off), .done(done), .timeout(timeout)
    );

    typedef struct {
        logic [23:0] oen;
        logic [23:0] odata;
        logic [15:0] lim;
        int          ack_after;
        int          exp_reads;
        bit          exp_done;
        int          exp_end;
        logic [31:0] exp_oen_w;
        logic [31:0] exp_set_w;
        logic [31:0] exp_clr_w;
    } vec_t;

    typedef struct {
        int          rel;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } pkt_t;

    vec_t vecs[6];
    pkt_t pkts[$];
    int   n_chk = 0, n_err = 0;
    int   done_cnt, to_cnt, end_rel, ho_first, ho_cnt, busy_cnt, hdr_err, post_pkts;
    int   rd_idx;
    bit   rd_pend;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [127:0] pk(input int rel, input logic wr, input logic [31:0] addr,
                                        input logic [31:0] data);
        return {32'(rel), 31'b0, wr, addr, data};
    endfunction

    task automatic log_cycle(input int k);
        if (reg_access) begin
            if (end_rel < 0)
                pkts.push_back('{rel: k, wr: reg_packet[0], addr: reg_packet[39:8],
                                 data: reg_packet[71:40]});
            else
                post_pkts++;
            if (reg_packet[7:1] !== 7'b0000010 || reg_packet[103:72] !== 32'h0) hdr_err++;
            if (!reg_packet[0]) rd_pend = 1'b1;
        end else if (reg_packet !== '0) begin
            hdr_err++;
        end
        if (done)    done_cnt++;
        if (timeout) to_cnt++;
        if (handed_off) begin
            ho_cnt++;
            if (ho_first < 0) ho_first = k;
        end
        if (busy) busy_cnt++;
        if ((done || timeout) && end_rel < 0) end_rel = k;
    endtask

    // Cycle 0 is the cycle start is high; every later cycle is logged relative to it.
    task automatic run_seq(input logic [23:0] oen, input logic [23:0] odata, input logic [15:0] lim,
                           input int ack_after, input int abort_rel, input int start2_rel);
        pkts.delete();
        done_cnt = 0; to_cnt = 0; end_rel = -1; ho_first = -1; ho_cnt = 0;
        busy_cnt = 0; hdr_err = 0; post_pkts = 0; rd_idx = 0; rd_pend = 1'b0;
        @(posedge clk); #1;
        oen_base = oen; odata_base = odata; timeout_lim = lim;
        reg_rdata = (ack_after == 0) ? ACK : NOACK;
        start = 1'b1; abort = 1'b0;
        @(negedge clk); log_cycle(0);
        for (int k = 1; k <= 300; k++) begin
            @(posedge clk); #1;
            start = (k == start2_rel);
            abort = (k == abort_rel);
            if (rd_pend) begin
                reg_rdata = (rd_idx >= ack_after) ? ACK : NOACK;
                rd_idx++;
                rd_pend = 1'b0;
            end
            @(negedge clk); log_cycle(k);
            if (end_rel >= 0 && k >= end_rel + 4) break;
        end
        start = 1'b0; abort = 1'b0;
    endtask

    task automatic check_vec(input int i, input vec_t v);
        string s;
        s = $sformatf("v%0d", i);
        chk({s, "_npkts"}, 128'(pkts.size()), 128'(3 + v.exp_reads));
        if (pkts.size() >= 3 + v.exp_reads) begin
            chk({s, "_oen"}, pk(pkts[0].rel, pkts[0].wr, pkts[0].addr, pkts[0].data),
                pk(1, 1'b1, 32'h0, v.exp_oen_w));
            chk({s, "_set"}, pk(pkts[1].rel, pkts[1].wr, pkts[1].addr, pkts[1].data),
                pk(2, 1'b1, 32'h8, v.exp_set_w));
            for (int r = 0; r < v.exp_reads; r++)
                chk($sformatf("%s_read%0d", s, r),
                    pk(pkts[2+r].rel, pkts[2+r].wr, pkts[2+r].addr, pkts[2+r].data),
                    pk(3 + 11*r, 1'b0, 32'h10, 32'h0));
            chk({s, "_clr"}, pk(pkts[2+v.exp_reads].rel, pkts[2+v.exp_reads].wr,
                                pkts[2+v.exp_reads].addr, pkts[2+v.exp_reads].data),
                pk(v.exp_end - 1, 1'b1, 32'h8, v.exp_clr_w));
        end
        chk({s, "_end"},     128'(end_rel),  128'(v.exp_end));
        chk({s, "_done"},    128'(done_cnt), 128'(v.exp_done ? 1 : 0));
        chk({s, "_timeout"}, 128'(to_cnt),   128'(v.exp_done ? 0 : 1));
        chk({s, "_ho_first"},128'(ho_first), 128'(2));
        chk({s, "_ho_cnt"},  128'(ho_cnt),   128'(v.exp_end - 3));
        chk({s, "_busy"},    128'(busy_cnt), 128'(v.exp_end));
        chk({s, "_hdr"},     128'(hdr_err),  128'(0));
        chk({s, "_post"},    128'(post_pkts),128'(0));
    endtask

    initial begin
        int cnt;
        vecs[0] = '{24'h000000, 24'h000000, 16'd5,  0,    1, 1'b1, 7,  32'h10,     32'h10,     32'h0};
        vecs[1] = '{24'h000000, 24'h000000, 16'd10, 3,    4, 1'b1, 40, 32'h10,     32'h10,     32'h0};
        vecs[2] = '{24'h000F00, 24'h00A0A0, 16'd2,  1000, 3, 1'b0, 29, 32'hF10,    32'hA0B0,   32'hA0A0};
        vecs[3] = '{24'h0000FF, 24'h000101, 16'd0,  0,    1, 1'b1, 7,  32'hFF,     32'h111,    32'h101};
        vecs[4] = '{24'h800000, 24'hFFFFFF, 16'd0,  1000, 1, 1'b0, 7,  32'h800010, 32'hFFFFFF, 32'hFFFFEF};
        vecs[5] = '{24'h000010, 24'h000010, 16'd1,  1,    2, 1'b1, 18, 32'h10,     32'h10,     32'h0};

        reset = 1'b1; start = 1'b0; abort = 1'b0; timeout_lim = '0;
        oen_base = '0; odata_base = '0; reg_rdata = NOACK;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_access",  128'(reg_access), 128'(0));
        chk("rst_packet",  128'(reg_packet), 128'(0));
        chk("rst_busy",    128'(busy),       128'(0));
        chk("rst_handed",  128'(handed_off), 128'(0));
        chk("rst_done",    128'(done),       128'(0));
        chk("rst_timeout", 128'(timeout),    128'(0));
        @(posedge clk); #1 reset = 1'b0;

        foreach (vecs[i]) begin
            run_seq(vecs[i].oen, vecs[i].odata, vecs[i].lim, vecs[i].ack_after, -1, -1);
            check_vec(i, vecs[i]);
        end

        // Abort in GAP (cycle 8) with a stray start during CHECK (cycle 5).
        run_seq(24'h000000, 24'h000001, 16'd10, 1000, 8, 5);
        chk("gap_npkts", 128'(pkts.size()), 128'(4));
        if (pkts.size() >= 4)
            chk("gap_clr", pk(pkts[3].rel, pkts[3].wr, pkts[3].addr, pkts[3].data),
                pk(9, 1'b1, 32'h8, 32'h1));
        chk("gap_end",     128'(end_rel),   128'(10));
        chk("gap_timeout", 128'(to_cnt),    128'(1));
        chk("gap_done",    128'(done_cnt),  128'(0));
        chk("gap_busy",    128'(busy_cnt),  128'(10));
        chk("gap_post",    128'(post_pkts), 128'(0));

        // Abort while the OEN write is out: no further writes, timeout pulse.
        run_seq(24'h000003, 24'h000000, 16'd5, 0, 1, -1);
        chk("cfg_npkts", 128'(pkts.size()), 128'(1));
        if (pkts.size() >= 1)
            chk("cfg_oen", pk(pkts[0].rel, pkts[0].wr, pkts[0].addr, pkts[0].data),
                pk(1, 1'b1, 32'h0, 32'h13));
        chk("cfg_end",     128'(end_rel),   128'(2));
        chk("cfg_timeout", 128'(to_cnt),    128'(1));
        chk("cfg_handed",  128'(ho_cnt),    128'(0));
        chk("cfg_busy",    128'(busy_cnt),  128'(1));
        chk("cfg_post",    128'(post_pkts), 128'(0));

        // start together with abort in IDLE does nothing.
        cnt = 0;
        @(posedge clk); #1 start = 1'b1; abort = 1'b1;
        @(posedge clk); #1 start = 1'b0; abort = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (busy || reg_access || done || timeout) cnt++;
        end
        chk("start_abort_idle", 128'(cnt), 128'(0));

        // Synchronous reset while waiting on a read.
        @(posedge clk); #1 odata_base = 24'h000101; oen_base = '0; timeout_lim = 16'd5;
        reg_rdata = NOACK; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("pre_rst_busy", 128'(busy), 128'(1));
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_outs", 128'({reg_access, busy, handed_off, done, timeout}), 128'(0));
        chk("mid_rst_pkt",  128'(reg_packet), 128'(0));
        cnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (busy || reg_access) cnt++;
        end
        chk("mid_rst_idle", 128'(cnt), 128'(0));
        run_seq(vecs[0].oen, vecs[0].odata, vecs[0].lim, vecs[0].ack_after, -1, -1);
        check_vec(10, vecs[0]);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
